// File: rtl/score_pixel_classifier.sv
// score_pixel_classifier
//
// Per-pixel classifier for the scrolling score display. Keeps a circular
// history of note columns in a small synchronous-read RAM and, for every
// active-video pixel, emits the pixel_type / instrument_type pair consumed
// by the colour stage. New columns arrive through a one-entry hold register
// and are committed only on frame_start, so a displayed frame never tears.
//
// Ports:
//   clk             pixel clock
//   reset_n         synchronous active-low reset
//   hcount, vcount  pixel coordinates (10 bits each)
//   pix_valid       active-video qualifier for hcount/vcount/text_on
//   frame_start     one-cycle pulse in vertical blanking; commit point
//   text_on         font-ROM hit for this pixel
//   note_valid      column write request
//   note_ready      hold register empty; write accepted on valid & ready
//   note_rest       column is a rest (draws no note pixels)
//   note_pitch      pitch index 0..15, 15 = top band
//   note_instr      instrument code
//   out_valid       pixel_type / instrument_type valid (2-cycle latency)
//   pixel_type      00 note, 01 staff line, 10 text, 11 background
//   instrument_type instrument of a note pixel, else 00
//   col_count       committed columns, saturating at NUM_COLS

module score_pixel_classifier #(
   parameter int NUM_COLS   = 64,
   parameter int COL_W_LOG2 = 3,
   parameter int ROW_H_LOG2 = 2,
   parameter int NOTE_TOP   = 144,
   parameter int STAFF_TOP  = 148,
   parameter int LINE_SP    = 12
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [9:0]                  hcount,
   input  logic [9:0]                  vcount,
   input  logic                        pix_valid,
   input  logic                        frame_start,
   input  logic                        text_on,
   input  logic                        note_valid,
   output logic                        note_ready,
   input  logic                        note_rest,
   input  logic [3:0]                  note_pitch,
   input  logic [1:0]                  note_instr,
   output logic                        out_valid,
   output logic [1:0]                  pixel_type,
   output logic [1:0]                  instrument_type,
   output logic [$clog2(NUM_COLS):0]   col_count
);

   localparam int PTR_W       = $clog2(NUM_COLS);
   localparam int CNT_W       = PTR_W + 1;
   localparam int BAND_SPAN   = 16 << ROW_H_LOG2;  // 16 pitch bands
   localparam int STAFF_LINES = 5;

   // Entry layout: {rest, pitch[3:0], instr[1:0]}
   logic [6:0]       r_hold_entry;
   logic             r_hold_full;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_col_count;
   logic [6:0]       r_mem [NUM_COLS];
   logic [6:0]       r_rd_entry;

   // Stage-1 registers
   logic             r_s1_valid;
   logic             r_s1_text;
   logic             r_s1_staff;
   logic             r_s1_exists;
   logic             r_s1_in_band;
   logic [3:0]       r_s1_band;

   // Stage-2 (output) registers
   logic             r_out_valid;
   logic [1:0]       r_pixel_type;
   logic [1:0]       r_instrument_type;

   logic             w_accept;
   logic             w_commit;
   logic             w_in_cols;
   logic [PTR_W-1:0] w_age;
   logic             w_exists;
   logic [PTR_W-1:0] w_rd_addr;
   logic             w_in_band;
   logic [3:0]       w_band;
   logic [STAFF_LINES-1:0] w_staff_hits;
   logic             w_staff;
   logic             w_note_hit;

   assign w_accept = note_valid & ~r_hold_full;
   assign w_commit = frame_start & r_hold_full;

   // ---------------- write side ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hold_full <= 1'b0;
         r_wr_ptr    <= '0;
         r_col_count <= '0;
      end else if (w_commit) begin
         r_hold_full <= 1'b0;
         r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
         if (r_col_count != CNT_W'(NUM_COLS))
            r_col_count <= r_col_count + CNT_W'(1);
      end else if (w_accept) begin
         r_hold_full <= 1'b1;
      end
   end

   // Payload needs no reset: it is only used while r_hold_full is set.
   always_ff @(posedge clk) begin
      if (w_accept)
         r_hold_entry <= {note_rest, note_pitch, note_instr};
   end

   // ---------------- column lookup ----------------
   // Newest column is drawn at the right edge, so age counts leftwards.
   assign w_in_cols = ((hcount >> COL_W_LOG2) < 10'(NUM_COLS));
   assign w_age     = PTR_W'(NUM_COLS - 1) - PTR_W'(hcount >> COL_W_LOG2);
   assign w_exists  = w_in_cols && ({1'b0, w_age} < r_col_count);
   assign w_rd_addr = r_wr_ptr - PTR_W'(1) - w_age;

   // Read returns the pre-write contents on a same-cycle commit, so pixels
   // already sampled keep seeing the old history.
   always_ff @(posedge clk) begin
      if (w_commit)
         r_mem[r_wr_ptr] <= r_hold_entry;
      r_rd_entry <= r_mem[w_rd_addr];
   end

   // ---------------- y decode ----------------
   assign w_in_band = (vcount >= 10'(NOTE_TOP)) && (vcount < 10'(NOTE_TOP + BAND_SPAN));
   assign w_band    = 4'((vcount - 10'(NOTE_TOP)) >> ROW_H_LOG2);

   generate
      for (genvar gi = 0; gi < STAFF_LINES; gi++) begin : g_staff
         assign w_staff_hits[gi] = (vcount == 10'(STAFF_TOP + gi * LINE_SP));
      end
   endgenerate
   assign w_staff = |w_staff_hits;

   // ---------------- stage 1 ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_text    <= 1'b0;
         r_s1_staff   <= 1'b0;
         r_s1_exists  <= 1'b0;
         r_s1_in_band <= 1'b0;
         r_s1_band    <= '0;
      end else begin
         r_s1_valid   <= pix_valid;
         r_s1_text    <= text_on;
         r_s1_staff   <= w_staff;
         r_s1_exists  <= w_exists;
         r_s1_in_band <= w_in_band;
         r_s1_band    <= w_band;
      end
   end

   // ---------------- stage 2 ----------------
   // Band index counts down from the top, so pitch p lives in band 15-p.
   assign w_note_hit = r_s1_exists & r_s1_in_band & ~r_rd_entry[6] &
                       (r_s1_band == (4'd15 - r_rd_entry[5:2]));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_out_valid       <= 1'b0;
         r_pixel_type      <= 2'b11;
         r_instrument_type <= 2'b00;
      end else begin
         r_out_valid <= r_s1_valid;
         if (!r_s1_valid) begin
            r_pixel_type      <= 2'b11;
            r_instrument_type <= 2'b00;
         end else if (w_note_hit) begin
            r_pixel_type      <= 2'b00;
            r_instrument_type <= r_rd_entry[1:0];
         end else if (r_s1_staff) begin
            r_pixel_type      <= 2'b01;
            r_instrument_type <= 2'b00;
         end else if (r_s1_text) begin
            r_pixel_type      <= 2'b10;
            r_instrument_type <= 2'b00;
         end else begin
            r_pixel_type      <= 2'b11;
            r_instrument_type <= 2'b00;
         end
      end
   end

   assign note_ready      = ~r_hold_full;
   assign col_count       = r_col_count;
   assign out_valid       = r_out_valid;
   assign pixel_type      = r_pixel_type;
   assign instrument_type = r_instrument_type;

endmodule

// File: tb/tb_score_pixel_classifier.sv
// tb_score_pixel_classifier
//
// Directed bench for score_pixel_classifier. Pixels are streamed one per
// cycle; each expected {out_valid, pixel_type, instrument_type} is held for
// one step and compared once the pipeline delivers it. Static pixel checks
// come from a vector table; writes, commits, handshake and wrap-around are
// hand-written sequences.

module tb_score_pixel_classifier;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] hcount, vcount;
   logic       pix_valid, frame_start, text_on;
   logic       note_valid, note_ready, note_rest;
   logic [3:0] note_pitch;
   logic [1:0] note_instr;
   logic       out_valid;
   logic [1:0] pixel_type, instrument_type;
   logic [6:0] col_count;

   always #5 clk = ~clk;

   score_pixel_classifier dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .hcount          (hcount),
      .vcount          (vcount),
      .pix_valid       (pix_valid),
      .frame_start     (frame_start),
      .text_on         (text_on),
      .note_valid      (note_valid),
      .note_ready      (note_ready),
      .note_rest       (note_rest),
      .note_pitch      (note_pitch),
      .note_instr      (note_instr),
      .out_valid       (out_valid),
      .pixel_type      (pixel_type),
      .instrument_type (instrument_type),
      .col_count       (col_count)
   );

   // {out_valid, pixel_type, instrument_type}
   localparam logic [4:0] E_IDLE  = 5'b0_11_00;
   localparam logic [4:0] E_STAFF = 5'b1_01_00;
   localparam logic [4:0] E_TEXT  = 5'b1_10_00;
   localparam logic [4:0] E_BG    = 5'b1_11_00;

   function automatic logic [4:0] en(input logic [1:0] instr);
      return {3'b1_00, instr};
   endfunction

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       pv;
      logic       txt;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   int n_cmp = 0;
   int n_err = 0;

   logic       pend_chk = 1'b0;
   logic [4:0] pend_exp;
   string      pend_nm;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [9:0] h, input logic [9:0] v, input logic pv,
                       input logic txt, input logic [4:0] exp, input string nm);
      hcount    = h;
      vcount    = v;
      pix_valid = pv;
      text_on   = txt;
      @(posedge clk);
      #1;
      if (pend_chk) begin
         $display("pix %s: out {valid,type,instr}=%b expect %b", pend_nm,
                  {out_valid, pixel_type, instrument_type}, pend_exp);
         check(pend_nm, {27'd0, out_valid, pixel_type, instrument_type}, {27'd0, pend_exp});
      end
      pend_chk = 1'b1;
      pend_exp = exp;
      pend_nm  = nm;
   endtask

   task automatic idle();
      step(10'd0, 10'd0, 1'b0, 1'b0, E_IDLE, "idle");
   endtask

   task automatic add(input int h, input int v, input logic pv, input logic txt,
                      input logic [4:0] exp);
      vec_t t;
      t.h   = 10'(h);
      t.v   = 10'(v);
      t.pv  = pv;
      t.txt = txt;
      t.exp = exp;
      tbl.push_back(t);
   endtask

   task automatic run_table(input int lo, input int hi, input string nm);
      for (int i = lo; i < hi; i++)
         step(tbl[i].h, tbl[i].v, tbl[i].pv, tbl[i].txt, tbl[i].exp,
              $sformatf("%s[%0d]", nm, i - lo));
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      repeat (3) idle();
      reset_n = 1'b1;
      check("reset_col_count", {25'd0, col_count}, 32'd0);
      check("reset_note_ready", {31'd0, note_ready}, 32'd1);
   endtask

   task automatic write_note(input logic rest, input logic [3:0] p, input logic [1:0] ins);
      check("ready_before_write", {31'd0, note_ready}, 32'd1);
      note_valid = 1'b1;
      note_rest  = rest;
      note_pitch = p;
      note_instr = ins;
      idle();
      note_valid = 1'b0;
      check("ready_after_accept", {31'd0, note_ready}, 32'd0);
   endtask

   task automatic commit(input int exp_cnt);
      frame_start = 1'b1;
      idle();
      frame_start = 1'b0;
      check("ready_after_commit", {31'd0, note_ready}, 32'd1);
      check("commit_col_count", {25'd0, col_count}, 32'(exp_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_empty, s_note, s_rest, s_wrap, s_end;
      logic exp_full;
      int n_acc;

      // ---------- vector tables ----------
      s_empty = tbl.size();
      add(300, 160, 1, 0, E_STAFF);
      add(300, 161, 1, 1, E_TEXT);
      add(300, 161, 1, 0, E_BG);
      add(300, 160, 1, 1, E_STAFF);   // staff beats text
      add(300, 161, 0, 1, E_IDLE);
      add(505, 184, 1, 0, E_STAFF);   // empty history
      add(505, 196, 1, 1, E_STAFF);
      add(505, 208, 1, 0, E_BG);
      add(0,   172, 1, 0, E_STAFF);
      add(1000,148, 1, 0, E_STAFF);
      s_note = tbl.size();
      add(505, 184, 1, 0, en(2'b10)); // note beats staff
      add(505, 187, 1, 0, en(2'b10));
      add(505, 188, 1, 0, E_BG);
      add(505, 183, 1, 0, E_BG);
      add(505, 190, 1, 0, E_BG);
      add(497, 185, 1, 0, E_BG);      // column not filled
      add(600, 185, 1, 0, E_BG);      // beyond note region
      add(504, 186, 1, 0, en(2'b10));
      add(503, 186, 1, 0, E_BG);
      add(505, 185, 0, 0, E_IDLE);
      add(505, 185, 1, 1, en(2'b10)); // note beats text
      s_rest = tbl.size();
      add(505, 205, 1, 0, E_BG);
      add(505, 185, 1, 0, E_BG);
      add(497, 185, 1, 0, en(2'b10)); // older note shifted left
      add(497, 184, 1, 0, en(2'b10));
      add(489, 185, 1, 0, E_BG);
      s_wrap = tbl.size();
      add(0,   201, 1, 0, en(2'b01)); // entry 1
      add(7,   201, 1, 0, en(2'b01));
      add(510, 205, 1, 0, en(2'b00)); // entry 64, pitch 0
      add(8,   201, 1, 0, E_BG);      // entry 2 is band 13
      add(8,   197, 1, 0, en(2'b10));
      add(8,   196, 1, 0, en(2'b10));
      add(502, 204, 1, 0, E_BG);      // entry 63 is band 0
      add(502, 145, 1, 0, en(2'b11));
      add(512, 205, 1, 0, E_BG);
      s_end = tbl.size();

      reset_n     = 1'b0;
      frame_start = 1'b0;
      note_valid  = 1'b0;
      note_rest   = 1'b0;
      note_pitch  = 4'd0;
      note_instr  = 2'd0;

      // ---------- reset with pixels streaming ----------
      repeat (3) step(10'd300, 10'd160, 1'b1, 1'b0, E_IDLE, "reset_stream");
      check("reset_col_count", {25'd0, col_count}, 32'd0);
      check("reset_note_ready", {31'd0, note_ready}, 32'd1);
      reset_n = 1'b1;
      idle();

      // ---------- empty history ----------
      run_table(s_empty, s_note, "empty");

      // ---------- single note; commit visibility ----------
      write_note(1'b0, 4'd5, 2'b10);
      frame_start = 1'b1;
      step(10'd505, 10'd185, 1'b1, 1'b0, E_BG, "same_cycle_as_commit");
      frame_start = 1'b0;
      step(10'd505, 10'd185, 1'b1, 1'b0, en(2'b10), "cycle_after_commit");
      check("single_col_count", {25'd0, col_count}, 32'd1);
      run_table(s_note, s_rest, "note");

      // ---------- rest column ----------
      write_note(1'b1, 4'd0, 2'b11);
      commit(2);
      run_table(s_rest, s_wrap, "rest");

      // ---------- handshake with continuous valid ----------
      do_reset();
      exp_full   = 1'b0;
      n_acc      = 0;
      note_valid = 1'b1;
      note_rest  = 1'b1;
      note_pitch = 4'd0;
      note_instr = 2'd0;
      for (int k = 0; k < 40; k++) begin
         check($sformatf("hs_ready[%0d]", k), {31'd0, note_ready}, {31'd0, ~exp_full});
         if (note_valid && note_ready) n_acc++;
         frame_start = (k == 10 || k == 20 || k == 30);
         if (frame_start && exp_full) exp_full = 1'b0;
         else if (!exp_full)          exp_full = 1'b1;
         idle();
      end
      frame_start = 1'b0;
      note_valid  = 1'b0;
      check("hs_accepts", 32'(n_acc), 32'd4);
      check("hs_col_count", {25'd0, col_count}, 32'd3);

      // ---------- wrap and overflow ----------
      do_reset();
      for (int i = 0; i <= 64; i++) begin
         write_note(1'b0, 4'(i % 16), 2'(i % 4));
         commit((i + 1 > 64) ? 64 : i + 1);
      end
      run_table(s_wrap, s_end, "wrap");

      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/score_pixel_classifier.md
# score_pixel_classifier

Per-pixel classifier for the scrolling score display, directly upstream of the colour stage. It stores a circular history of detected note columns and, for each active-video pixel from the display timing generator, outputs the `pixel_type` / `instrument_type` pair that the colour stage turns into RGB. New note columns are written through a valid/ready handshake and committed only at frame start, so a frame never tears.

## Interface
Parameters:
- `NUM_COLS`, 64: history depth in columns; power of two.
- `COL_W_LOG2`, 3: log2 of column width in pixels (8 px).
- `ROW_H_LOG2`, 2: log2 of pitch-band height in pixels (4 px).
- `NOTE_TOP`, 144: y of the top of the pitch-15 band.
- `STAFF_TOP`, 148: y of the first staff line.
- `LINE_SP`, 12: staff line spacing; 5 lines.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: synchronous, active-low reset.
- `hcount` in 10: pixel x.
- `vcount` in 10: pixel y.
- `pix_valid` in 1: active-video qualifier for hcount/vcount/text_on.
- `frame_start` in 1: one-cycle pulse in vertical blanking.
- `text_on` in 1: font-ROM hit for this pixel.
- `note_valid` in 1: write request.
- `note_ready` out 1: write accepted when valid&ready.
- `note_rest` in 1: column is a rest; no note pixels.
- `note_pitch` in 4: pitch index 0–15; 15 is the top band.
- `note_instr` in 2: instrument code: 00 violin, 01 piano, 10 electric, 11 default.
- `out_valid` out 1: pixel_type/instrument_type valid.
- `pixel_type` out 2: 00 note, 01 staff line, 10 text, 11 background.
- `instrument_type` out 2: instrument of a note pixel, else 00.
- `col_count` out 7: committed columns, 0..NUM_COLS.

## Operation
- Hold register: one entry {rest, pitch, instr}. `note_ready = ~hold_full`. On valid&ready, load the entry and set hold_full.
- Commit: in a cycle with `frame_start` & hold_full, write the entry to `buf[wr_ptr]`, advance `wr_ptr` mod NUM_COLS, increment `col_count` with saturation at NUM_COLS, and clear hold_full. When the buffer is full, the write overwrites the oldest entry. `frame_start` with the hold register empty does nothing.
- Column mapping: `c = hcount >> COL_W_LOG2`. Note lookup applies only when `c < NUM_COLS`.
  - `age = NUM_COLS-1-c`; the newest column is the rightmost.
  - The entry exists only when `age < col_count`.
  - Address is `(wr_ptr-1-age) mod NUM_COLS`.
- Note hit: the entry exists, is not a rest, and `(vcount-NOTE_TOP) >> ROW_H_LOG2 == 15-pitch`, with `vcount` in `[NOTE_TOP, NOTE_TOP+64)`.
- Staff hit: `vcount == STAFF_TOP + k*LINE_SP` for k = 0..4, at any x.
- Priority: note > staff > text > background. `instrument_type` is the entry's instr only on a note hit.
- When `pix_valid=0`: `out_valid=0`, `pixel_type=11`, `instrument_type=00`.
- Buffer is a synchronous-read RAM of `NUM_COLS` x 7 bits.

## Timing
- Latency is 2 cycles. Inputs sampled at T produce outputs registered at T+2. Throughput is 1 pixel/cycle with no stalls.
  - Stage 1: RAM read; y decode, text_on, pix_valid and age check registered.
  - Stage 2: priority mux, output registers.
- Commit at T is visible to pixels sampled at T+1 or later. Pixels already in the pipeline use the old state.
- `note_ready` drops the cycle after an accept and rises the cycle after the commit. Back-to-back writes are therefore limited to one per frame.
- Reset values, one cycle after `reset_n` is sampled low:
  - outputs: `out_valid=0`, `pixel_type=11`, `instrument_type=00`, `col_count=0`, `note_ready=1`;
  - internal state: `wr_ptr=0`, hold_full=0, pipeline valids cleared.
- Reset mid-frame or mid-handshake discards the held entry and all history. RAM contents are don't-care because `col_count=0`.

## Test plan
- Reset: hold `reset_n` low for 3 cycles with pixels streaming → `out_valid=0`, `pixel_type=11`, `col_count=0`, `note_ready=1`.
- Empty staff: pixel (300,160) → 2 cycles later `out_valid=1`, `pixel_type=01`. Pixel (300,161) with `text_on=1` → type 10. Pixel (300,161) with `text_on=0` → type 11.
- Single note: write pitch 5, instr 10; pulse `frame_start`.
  - (505,184) → type 00, instr 10; note beats the staff line at y=184.
  - (505,190) → type 01? No: y=190 is not a staff line → 11.
  - (497,185) → 11; column not filled.
  - (600,185) → 11; beyond the note region.
- Handshake: assert `note_valid` continuously → exactly one accept per `frame_start`; `note_ready` low between the accept and the commit.
- Wrap and overflow: commit 65 columns with pitch = i mod 16 and instr = i mod 4 → `col_count=64`.
  - (0,201) → type 00, instr 01; this is entry i=1.
  - (510,205) → type 00, instr 00; this is entry i=64, pitch 0.
- Rest: commit a rest column → (505, any note-band y that is not a staff line) → 11.
